// File: rtl/pong_pkg.sv
// Shared pong constants: screen geometry, object sizes, reset positions and
// game state encoding. Also used by the pixel-graphics stage.
package pong_pkg;

  localparam logic [9:0] MAX_X       = 10'd640;
  localparam logic [9:0] MAX_Y       = 10'd480;
  localparam logic [9:0] WALL_X_L    = 10'd32;
  localparam logic [9:0] WALL_X_R    = 10'd35;
  localparam logic [9:0] BAR_X_L     = 10'd600;
  localparam logic [9:0] BAR_X_R     = 10'd603;
  localparam logic [9:0] BAR_Y_SIZE  = 10'd72;
  localparam logic [9:0] BALL_SIZE   = 10'd8;

  // Scene reset positions and the scan row that marks end of visible frame
  localparam logic [9:0] BAR_Y_INIT  = 10'd204;
  localparam logic [9:0] BALL_X_INIT = 10'd316;
  localparam logic [9:0] BALL_Y_INIT = 10'd236;
  localparam logic [9:0] TICK_ROW    = 10'd481;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_MISS = 2'b10
  } game_state_e;

  // Two's complement negate of a 10-bit velocity
  function automatic logic [9:0] neg10(input logic [9:0] a);
    return (~a) + 10'd1;
  endfunction

endpackage

// File: rtl/pong_frame_tick.sv
// Frame tick generator: one clk pulse the cycle after the scan reaches
// column 0 of row 481. Edge-detected so a slow pixel enable that holds the
// scan position for several clocks still yields a single tick.
module pong_frame_tick
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       refr_tick
);

  logic match_s;
  logic match_q;
  logic refr_tick_d;
  logic refr_tick_q;

  assign match_s     = (pix_x == 10'd0) && (pix_y == TICK_ROW);
  assign refr_tick_d = match_s && !match_q;

  // Register the scan match and the rising-edge tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q     <= 1'b0;
      refr_tick_q <= 1'b0;
    end else begin
      match_q     <= match_s;
      refr_tick_q <= refr_tick_d;
    end
  end

  assign refr_tick = refr_tick_q;

endmodule

// File: rtl/pong_motion_ctrl.sv
// Pong motion controller: paddle and ball motion plus the IDLE/PLAY/MISS
// game FSM, all advanced once per frame tick.
// Optional build macro PONG_SPEEDUP_EN: each paddle hit raises the ball
// speed by one pixel/frame up to BALL_V_MAX; speed resets on return to IDLE.
module pong_motion_ctrl
  import pong_pkg::*;
#(
  parameter int BAR_V       = 4,
  parameter int BALL_V      = 2,
  parameter int BALL_V_MAX  = 6,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [9:0] bar_y_t,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_visible,
  output logic       miss_pulse,
  output logic [1:0] game_state,
  output logic       refr_tick
);

`ifdef PONG_SPEEDUP_EN
  localparam bit SPEEDUP_ON = 1'b1;
`else
  localparam bit SPEEDUP_ON = 1'b0;
`endif

  localparam logic [9:0] BAR_V_W      = 10'(BAR_V);
  localparam logic [9:0] BALL_V_W     = 10'(BALL_V);
  localparam logic [9:0] BALL_V_MAX_W = 10'(BALL_V_MAX);
  localparam logic [5:0] MISS_LAST    = 6'(MISS_FRAMES - 1);
  localparam logic [9:0] BAR_DN_LIM   = (MAX_Y - 10'd1) - BAR_V_W;
  localparam logic [9:0] WALL_LIM     = WALL_X_R + 10'd1;

  logic        refr_tick_s;
  logic [9:0]  bar_y_t_q, bar_y_t_d;
  logic [9:0]  ball_x_q, ball_x_d;
  logic [9:0]  ball_y_q, ball_y_d;
  logic [9:0]  dx_q, dx_d;
  logic [9:0]  dy_q, dy_d;
  logic [9:0]  vel_q, vel_d;
  logic [5:0]  miss_cnt_q, miss_cnt_d;
  logic        ball_visible_q, ball_visible_d;
  logic        miss_pulse_q, miss_pulse_d;
  game_state_e state_q, state_d;

  logic [9:0]  ball_r_s, ball_b_s, bar_b_s;
  logic        top_s, bot_s, wall_s, hit_s, miss_s;
  logic [9:0]  vel_nxt_s;

  pong_frame_tick u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .refr_tick (refr_tick_s)
  );

  // Collision flags from pre-update positions, and the speed to apply
  always_comb begin
    ball_r_s  = ball_x_q + (BALL_SIZE - 10'd1);
    ball_b_s  = ball_y_q + (BALL_SIZE - 10'd1);
    bar_b_s   = bar_y_t_q + (BAR_Y_SIZE - 10'd1);
    top_s     = (ball_y_q <= vel_q);
    bot_s     = (ball_b_s >= ((MAX_Y - 10'd1) - vel_q));
    wall_s    = (ball_x_q <= WALL_LIM);
    hit_s     = (state_q == ST_PLAY) && !dx_q[9] && (dx_q != 10'd0) &&
                (ball_r_s >= BAR_X_L) && (ball_r_s <= BAR_X_R) &&
                (ball_b_s >= bar_y_t_q) && (ball_y_q <= bar_b_s);
    miss_s    = (state_q == ST_PLAY) && (ball_r_s > BAR_X_R) && !hit_s;
    if (SPEEDUP_ON && hit_s && (vel_q < BALL_V_MAX_W)) begin
      vel_nxt_s = vel_q + 10'd1;
    end else begin
      vel_nxt_s = vel_q;
    end
  end

  // Next-state for paddle, ball, velocity and game FSM; changes only on tick
  always_comb begin
    bar_y_t_d      = bar_y_t_q;
    ball_x_d       = ball_x_q;
    ball_y_d       = ball_y_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    vel_d          = vel_q;
    miss_cnt_d     = miss_cnt_q;
    ball_visible_d = ball_visible_q;
    miss_pulse_d   = 1'b0;
    state_d        = state_q;
    if (refr_tick_s) begin
      if (btn_down && !btn_up && (bar_b_s < BAR_DN_LIM)) begin
        bar_y_t_d = bar_y_t_q + BAR_V_W;
      end else if (btn_up && !btn_down && (bar_y_t_q > BAR_V_W)) begin
        bar_y_t_d = bar_y_t_q - BAR_V_W;
      end else begin
        bar_y_t_d = bar_y_t_q;
      end
      case (state_q)
        ST_IDLE: begin
          ball_x_d       = BALL_X_INIT;
          ball_y_d       = BALL_Y_INIT;
          dx_d           = neg10(BALL_V_W);
          dy_d           = BALL_V_W;
          vel_d          = BALL_V_W;
          ball_visible_d = 1'b1;
          if (btn_start) state_d = ST_PLAY;
          else           state_d = ST_IDLE;
        end
        ST_PLAY: begin
          ball_x_d = ball_x_q + dx_q;
          ball_y_d = ball_y_q + dy_q;
          vel_d    = vel_nxt_s;
          // Reflections keep the current direction unless a boundary flips it
          if (top_s)         dy_d = vel_nxt_s;
          else if (bot_s)    dy_d = neg10(vel_nxt_s);
          else if (dy_q[9])  dy_d = neg10(vel_nxt_s);
          else               dy_d = vel_nxt_s;
          if (wall_s)        dx_d = vel_nxt_s;
          else if (hit_s)    dx_d = neg10(vel_nxt_s);
          else if (dx_q[9])  dx_d = neg10(vel_nxt_s);
          else               dx_d = vel_nxt_s;
          if (miss_s) begin
            state_d        = ST_MISS;
            miss_pulse_d   = 1'b1;
            ball_visible_d = 1'b0;
            miss_cnt_d     = 6'd0;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_MISS: begin
          if (miss_cnt_q == MISS_LAST) begin
            state_d        = ST_IDLE;
            miss_cnt_d     = 6'd0;
            ball_visible_d = 1'b1;
            ball_x_d       = BALL_X_INIT;
            ball_y_d       = BALL_Y_INIT;
            dx_d           = neg10(BALL_V_W);
            dy_d           = BALL_V_W;
            vel_d          = BALL_V_W;
          end else begin
            miss_cnt_d = miss_cnt_q + 6'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Scene state registers with asynchronous reset to the serve position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_y_t_q      <= BAR_Y_INIT;
      ball_x_q       <= BALL_X_INIT;
      ball_y_q       <= BALL_Y_INIT;
      dx_q           <= neg10(BALL_V_W);
      dy_q           <= BALL_V_W;
      vel_q          <= BALL_V_W;
      miss_cnt_q     <= 6'd0;
      ball_visible_q <= 1'b1;
      miss_pulse_q   <= 1'b0;
      state_q        <= ST_IDLE;
    end else begin
      bar_y_t_q      <= bar_y_t_d;
      ball_x_q       <= ball_x_d;
      ball_y_q       <= ball_y_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      vel_q          <= vel_d;
      miss_cnt_q     <= miss_cnt_d;
      ball_visible_q <= ball_visible_d;
      miss_pulse_q   <= miss_pulse_d;
      state_q        <= state_d;
    end
  end

  assign bar_y_t      = bar_y_t_q;
  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign ball_visible = ball_visible_q;
  assign miss_pulse   = miss_pulse_q;
  assign game_state   = state_q;
  assign refr_tick    = refr_tick_s;

endmodule
